// File: rtl/seq_101_pkg.sv
// Shared definitions for the "101" serial link: the transmitter (seq_101_tx)
// and the next revision of the Mealy "101" detector.
package seq_101_pkg;

   // 2-bit FSM state shared by the transmitter and the detector.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PRE   = 2'b01,
      SHIFT = 2'b10,
      DONE  = 2'b11
   } state_e;

   // Frame-start marker, sent first bit (bit 2) to last bit (bit 0).
   localparam logic [2:0]  PREAMBLE     = 3'b101;
   localparam int unsigned PREAMBLE_LEN = 3;

endpackage : seq_101_pkg

// File: rtl/seq_101_shreg.sv
// WIDTH-bit loadable shift register. head_bit is the bit that is emitted next:
// bit WIDTH-1 when MSB_FIRST=1, otherwise bit 0. Zeros are shifted in.
module seq_101_shreg #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] data_in,
   output logic             head_bit
);

   logic [WIDTH-1:0] sr_q, sr_d;

   // Load has priority over shift; otherwise hold.
   always_comb begin
      sr_d = sr_q;
      if (load) begin
         sr_d = data_in;
      end else if (shift_en) begin
         sr_d = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
      end
   end

   // Register with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign head_bit = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule : seq_101_shreg

// File: rtl/seq_101_tx.sv
// Serial transmitter for the "101" link: accepts a WIDTH-bit word on
// load && ready and shifts it out one bit per clock on `out`, all outputs
// registered. Define SEQ_101_TX_PREAMBLE_EN to prefix each frame with the
// 1,0,1 preamble so the downstream detector flags frame start.
module seq_101_tx
   import seq_101_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             out,
   output logic             out_valid,
   output logic             done
);

   localparam int unsigned     CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ready_q, ready_d;
   logic            out_q, out_d;
   logic            out_valid_q, out_valid_d;
   logic            done_q, done_d;

   logic             sh_load, sh_shift, sh_head;
   logic [WIDTH-1:0] sh_data;
   logic             in_head;
   logic [WIDTH-1:0] in_next;

`ifdef SEQ_101_TX_PREAMBLE_EN
   logic [1:0]      pre_cnt_q, pre_cnt_d;
`endif

   seq_101_shreg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shreg (
      .clk      (clk),
      .rst      (rst),
      .load     (sh_load),
      .shift_en (sh_shift),
      .data_in  (sh_data),
      .head_bit (sh_head)
   );

   // Head bit of the incoming word and the word with that bit already consumed.
   always_comb begin
      in_head = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
      in_next = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
   end

   // Next-state and next-output logic. Outputs are registered, so each branch
   // computes what the pins show in the following cycle. Because the first
   // payload bit must be on `out` right after accept, it is taken directly from
   // data_in and the shift register is loaded with the remaining bits; from then
   // on sh_head always holds the bit due in the next cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ready_d     = 1'b0;
      out_d       = 1'b0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      sh_load     = 1'b0;
      sh_shift    = 1'b0;
      sh_data     = data_in;
`ifdef SEQ_101_TX_PREAMBLE_EN
      pre_cnt_d   = pre_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (load && ready_q) begin
               sh_load     = 1'b1;
               cnt_d       = '0;
               ready_d     = 1'b0;
               out_valid_d = 1'b1;
`ifdef SEQ_101_TX_PREAMBLE_EN
               state_d     = PRE;
               pre_cnt_d   = '0;
               out_d       = PREAMBLE[2];
`else
               state_d     = SHIFT;
               out_d       = in_head;
               sh_data     = in_next;
`endif
            end
         end
`ifdef SEQ_101_TX_PREAMBLE_EN
         PRE: begin
            out_valid_d = 1'b1;
            pre_cnt_d   = pre_cnt_q + 2'd1;
            if (pre_cnt_q == 2'(PREAMBLE_LEN - 1)) begin
               state_d  = SHIFT;
               out_d    = sh_head;
               sh_shift = 1'b1;
            end else begin
               out_d = (pre_cnt_q == 2'd0) ? PREAMBLE[1] : PREAMBLE[0];
            end
         end
`endif
         SHIFT: begin
            cnt_d    = cnt_q + CW'(1);
            sh_shift = 1'b1;
            if (cnt_q == LAST) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               out_d       = sh_head;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ready_q     <= 1'b1;
         out_q       <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

`ifdef SEQ_101_TX_PREAMBLE_EN
   // Preamble bit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end
`endif

   assign ready     = ready_q;
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;

endmodule : seq_101_tx

// File: tb/tb_seq_101_tx.sv
// Directed bench for seq_101_tx: MSB-first and LSB-first WIDTH=8 instances and
// a WIDTH=1 instance. Follows SEQ_101_TX_PREAMBLE_EN when defined.
module tb_seq_101_tx;

`ifdef SEQ_101_TX_PREAMBLE_EN
   localparam int P = 3;
`else
   localparam int P = 0;
`endif

   logic       clk;
   logic       rst;
   logic       ld   [3];
   logic [7:0] dat8 [2];
   logic       dat1;
   logic       rdy  [3];
   logic       so   [3];
   logic       ov   [3];
   logic       dn   [3];
   logic [1:0] hist [3];

   int n_chk  = 0;
   int n_pass = 0;

   seq_101_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .data_in(dat8[0]), .load(ld[0]),
      .ready(rdy[0]), .out(so[0]), .out_valid(ov[0]), .done(dn[0]));

   seq_101_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .data_in(dat8[1]), .load(ld[1]),
      .ready(rdy[1]), .out(so[1]), .out_valid(ov[1]), .done(dn[1]));

   seq_101_tx #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1 (
      .clk(clk), .rst(rst), .data_in(dat1), .load(ld[2]),
      .ready(rdy[2]), .out(so[2]), .out_valid(ov[2]), .done(dn[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference Mealy "101" detector history on each serial line.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) hist[i] <= {hist[i][0], so[i]};
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
   endtask

   task automatic drive(input int d, input logic l, input logic [7:0] v);
      ld[d] = l;
      if (d < 2) dat8[d] = v;
      else       dat1 = v[0];
   endtask

   // seq holds the expected payload in send order, first bit at seq[7].
   task automatic run_frame(input int d, input logic [7:0] v, input logic [7:0] seq,
                            input int nb, input string tag);
      logic [2:0] pre;
      pre = 3'b101;
      @(negedge clk);
      chk({tag, "_rdy_pre"}, 32'(rdy[d]), 1);
      drive(d, 1'b1, v);
      for (int p = 0; p < P; p++) begin
         @(negedge clk);
         drive(d, 1'b0, ~v);
         chk({tag, "_pre_out"}, 32'(so[d]), 32'(pre[2-p]));
         chk({tag, "_pre_vld"}, 32'(ov[d]), 1);
         if (p == 2) chk({tag, "_det"}, 32'(hist[d] == 2'b10 && so[d]), 1);
      end
      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         drive(d, 1'b0, ~v);
         chk({tag, "_out"}, 32'(so[d]), 32'(seq[7-i]));
         chk({tag, "_vld"}, 32'(ov[d]), 1);
         chk({tag, "_rdy_busy"}, 32'(rdy[d]), 0);
         chk({tag, "_done_early"}, 32'(dn[d]), 0);
      end
      @(negedge clk);
      chk({tag, "_done"}, 32'(dn[d]), 1);
      chk({tag, "_done_out"}, 32'(so[d]), 0);
      chk({tag, "_done_vld"}, 32'(ov[d]), 0);
      chk({tag, "_done_rdy"}, 32'(rdy[d]), 0);
      @(negedge clk);
      chk({tag, "_rdy_post"}, 32'(rdy[d]), 1);
      chk({tag, "_done_1cyc"}, 32'(dn[d]), 0);
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state held while idle.
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            chk("idle_rdy", 32'(rdy[d]), 1);
            chk("idle_out", 32'(so[d]), 0);
            chk("idle_vld", 32'(ov[d]), 0);
            chk("idle_done", 32'(dn[d]), 0);
         end
      end

      run_frame(0, 8'hA5, 8'b1010_0101, 8, "msb_a5");
      run_frame(1, 8'h0D, 8'b1011_0000, 8, "lsb_0d");
      run_frame(0, 8'h3C, 8'b0011_1100, 8, "msb_3c");
      run_frame(1, 8'h80, 8'b0000_0001, 8, "lsb_80");
      run_frame(2, 8'h01, 8'b1000_0000, 1, "w1_one");
      run_frame(2, 8'h00, 8'b0000_0000, 1, "w1_zero");

      // load held high: second frame accepted only once ready returns.
      @(negedge clk);
      drive(0, 1'b1, 8'hFF);
      for (int i = 0; i < P + 8; i++) begin
         @(negedge clk);
         drive(0, 1'b1, 8'h00);
         chk("hold_out", 32'(so[0]), (i == 1 && P == 3) ? 0 : 1);
         chk("hold_rdy", 32'(rdy[0]), 0);
      end
      @(negedge clk);
      chk("hold_done", 32'(dn[0]), 1);
      @(negedge clk);
      chk("hold_rdy_back", 32'(rdy[0]), 1);
      @(negedge clk);
      drive(0, 1'b0, 8'h00);
      chk("hold_2nd_out", 32'(so[0]), (P == 3) ? 1 : 0);
      chk("hold_2nd_vld", 32'(ov[0]), 1);
      chk("hold_2nd_rdy", 32'(rdy[0]), 0);
      begin
         int budget;
         budget = 0;
         while (rdy[0] !== 1'b1 && budget < 30) begin
            @(negedge clk);
            budget++;
         end
         chk("hold_drain", 32'(rdy[0]), 1);
      end

      // Reset mid-frame: frame abandoned, no done pulse.
      @(negedge clk);
      drive(0, 1'b1, 8'hA5);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         drive(0, 1'b0, 8'h00);
      end
      @(negedge clk);
      chk("rst_mid_active", 32'(ov[0]), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_out", 32'(so[0]), 0);
      chk("rst_vld", 32'(ov[0]), 0);
      chk("rst_rdy", 32'(rdy[0]), 1);
      chk("rst_done", 32'(dn[0]), 0);
      for (int k = 6; k <= P + 11; k++) begin
         @(negedge clk);
         chk("rst_no_done", 32'(dn[0]), 0);
         chk("rst_no_vld", 32'(ov[0]), 0);
      end

      run_frame(0, 8'h5A, 8'b0101_1010, 8, "msb_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_seq_101_tx
